// File: rtl/bascomp_io_terminal.sv
// Terminal side of the basic computer I/O: keyboard FIFO -> INPR/FGI, OUTR/FGO -> paced printer.
// Latency: keyboard byte reaches inpr one edge after it is queued; fgo returns PRINT_DELAY edges after the printer handshake.
// Backpressure: kbd_ready drops while the FIFO is full; prn_valid/prn_data hold steady until prn_ready.
module bascomp_io_terminal #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PRINT_DELAY = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic [7:0] inpr,
  output logic       fgi,
  input  logic       cpu_inp,
  input  logic       cpu_out,
  input  logic [7:0] cpu_outr,
  output logic       fgo,
  output logic       prn_valid,
  output logic [7:0] prn_data,
  input  logic       prn_ready,
  input  logic       ien_set,
  input  logic       ien_clr,
  input  logic       int_ack,
  output logic       ien,
  output logic       irq,
  output logic       ovr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (PRINT_DELAY > 1) ? $clog2(PRINT_DELAY) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  // Counter is preloaded with one less than the delay: the handshake edge itself is not a busy cycle.
  localparam logic [CW-1:0] DLY_LOAD = (PRINT_DELAY > 0) ? CW'(PRINT_DELAY - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DELAY} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    inpr_q, inpr_d, prn_data_q, prn_data_d;
  logic          fgi_q, fgi_d, fgo_q, fgo_d, ien_q, ien_d, ovr_q, ovr_d;
  logic [CW-1:0] dly_q, dly_d;
  state_t        state_q, state_d;

  logic full, empty, push, pop;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign push      = kbd_valid & ~full;
  // Refill only when INPR is free, so it can never coincide with the cpu_inp clear edge.
  assign pop       = ~fgi_q & ~empty;

  assign kbd_ready = ~full;
  assign inpr      = inpr_q;
  assign fgi       = fgi_q;
  assign fgo       = fgo_q;
  assign prn_valid = (state_q == S_SEND);
  assign prn_data  = prn_data_q;
  assign ien       = ien_q;
  assign ovr       = ovr_q;
  assign irq       = ien_q & (fgi_q | fgo_q);

  // Keyboard FIFO bookkeeping, INPR refill, interrupt enable and protocol-error tracking.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    inpr_d   = inpr_q;
    fgi_d    = fgi_q;
    ien_d    = ien_q;
    ovr_d    = ovr_q | (cpu_inp & ~fgi_q) | (cpu_out & ~fgo_q);

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      inpr_d   = mem_q[rd_ptr_q];
      fgi_d    = 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    if (cpu_inp && fgi_q) fgi_d = 1'b0;

    // Clear beats set when both arrive on the same edge.
    if (ien_clr || int_ack) ien_d = 1'b0;
    else if (ien_set)       ien_d = 1'b1;
  end

  // Printer FSM: accept OUTR when idle, hold it until the handshake, then count the print delay.
  always_comb begin
    state_d    = state_q;
    fgo_d      = fgo_q;
    prn_data_d = prn_data_q;
    dly_d      = dly_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_out && fgo_q) begin
          prn_data_d = cpu_outr;
          fgo_d      = 1'b0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (prn_ready) begin
          if (PRINT_DELAY == 0) begin
            fgo_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            dly_d   = DLY_LOAD;
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == '0) begin
          fgo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= kbd_data;
  end

  // State registers with synchronous reset; reset abandons any print and discards buffered bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      inpr_q     <= '0;
      fgi_q      <= 1'b0;
      fgo_q      <= 1'b1;
      prn_data_q <= '0;
      ien_q      <= 1'b0;
      ovr_q      <= 1'b0;
      dly_q      <= '0;
      state_q    <= S_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      inpr_q     <= inpr_d;
      fgi_q      <= fgi_d;
      fgo_q      <= fgo_d;
      prn_data_q <= prn_data_d;
      ien_q      <= ien_d;
      ovr_q      <= ovr_d;
      dly_q      <= dly_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_bascomp_io_terminal.sv
// Directed bench for bascomp_io_terminal (FIFO_DEPTH=4, PRINT_DELAY=3).
// Inputs change on the falling edge; outputs are sampled on the next falling edge.
module tb_bascomp_io_terminal;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clock = 1'b0;
  logic       reset;
  logic       kbd_valid;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic [7:0] inpr;
  logic       fgi;
  logic       cpu_inp;
  logic       cpu_out;
  logic [7:0] cpu_outr;
  logic       fgo;
  logic       prn_valid;
  logic [7:0] prn_data;
  logic       prn_ready;
  logic       ien_set;
  logic       ien_clr;
  logic       int_ack;
  logic       ien;
  logic       irq;
  logic       ovr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bascomp_io_terminal #(.FIFO_DEPTH(4), .PRINT_DELAY(3)) dut (
    .clock(clock), .reset(reset),
    .kbd_valid(kbd_valid), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .inpr(inpr), .fgi(fgi), .cpu_inp(cpu_inp),
    .cpu_out(cpu_out), .cpu_outr(cpu_outr), .fgo(fgo),
    .prn_valid(prn_valid), .prn_data(prn_data), .prn_ready(prn_ready),
    .ien_set(ien_set), .ien_clr(ien_clr), .int_ack(int_ack),
    .ien(ien), .irq(irq), .ovr(ovr)
  );

  typedef struct packed {
    logic       rst;
    logic       kv;
    logic [7:0] kd;
    logic       inp;
    logic       out;
    logic [7:0] outr;
    logic       prdy;
    logic       iset;
    logic       iclr;
    logic       iack;
    logic       e_kr;
    logic [7:0] e_inpr;
    logic       e_fgi;
    logic       e_fgo;
    logic       e_pv;
    logic [7:0] e_pd;
    logic       e_ien;
    logic       e_irq;
    logic       e_ovr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; kbd_valid = 1'b0; kbd_data = 8'h00; cpu_inp = 1'b0; cpu_out = 1'b0;
    cpu_outr = 8'h00; prn_ready = 1'b0; ien_set = 1'b0; ien_clr = 1'b0; int_ack = 1'b0;
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_h(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Waits up to a few cycles for fgi; an expired wait is recorded as a failure.
  task automatic wait_fgi(input string name);
    int k;
    k = 0;
    while (fgi !== 1'b1 && k < 6) begin
      tick();
      k++;
    end
    check_b(name, fgi, 1'b1);
  endtask

  initial begin
    logic [22:0] got, exp;

    //          rst kv kd     inp out outr   prdy iset iclr iack | kr inpr  fgi fgo pv pd     ien irq ovr
    vecs[0]  = '{H, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h00, L, H, L, 8'h00, L, L, L};
    vecs[1]  = '{L, L, 8'h00, L, L, 8'h00, L, H, L, L,  H, 8'h00, L, H, L, 8'h00, H, H, L};
    vecs[2]  = '{L, L, 8'h00, L, L, 8'h00, L, H, L, H,  H, 8'h00, L, H, L, 8'h00, L, L, L};
    vecs[3]  = '{L, L, 8'h00, L, L, 8'h00, L, H, H, L,  H, 8'h00, L, H, L, 8'h00, L, L, L};
    vecs[4]  = '{L, L, 8'h00, L, L, 8'h00, L, H, L, L,  H, 8'h00, L, H, L, 8'h00, H, H, L};
    vecs[5]  = '{L, H, 8'h41, L, L, 8'h00, L, L, L, L,  H, 8'h00, L, H, L, 8'h00, H, H, L};
    vecs[6]  = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, H, H, L, 8'h00, H, H, L};
    vecs[7]  = '{L, L, 8'h00, H, L, 8'h00, L, L, L, L,  H, 8'h41, L, H, L, 8'h00, H, H, L};
    vecs[8]  = '{L, L, 8'h00, L, H, 8'h5A, L, L, L, L,  H, 8'h41, L, L, H, 8'h5A, H, L, L};
    vecs[9]  = '{L, L, 8'h00, L, H, 8'h77, L, L, L, L,  H, 8'h41, L, L, H, 8'h5A, H, L, H};
    vecs[10] = '{L, L, 8'h00, H, L, 8'h00, L, L, L, L,  H, 8'h41, L, L, H, 8'h5A, H, L, H};
    vecs[11] = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, L, L, H, 8'h5A, H, L, H};
    vecs[12] = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, L, L, H, 8'h5A, H, L, H};
    vecs[13] = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, L, L, H, 8'h5A, H, L, H};
    vecs[14] = '{L, L, 8'h00, L, L, 8'h00, H, L, L, L,  H, 8'h41, L, L, L, 8'h5A, H, L, H};
    vecs[15] = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, L, L, L, 8'h5A, H, L, H};
    vecs[16] = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, L, L, L, 8'h5A, H, L, H};
    vecs[17] = '{L, L, 8'h00, L, L, 8'h00, L, L, L, L,  H, 8'h41, L, H, L, 8'h5A, H, H, H};

    idle_inputs();

    for (int i = 0; i < NV; i++) begin
      reset = vecs[i].rst;   kbd_valid = vecs[i].kv;  kbd_data = vecs[i].kd;
      cpu_inp = vecs[i].inp; cpu_out = vecs[i].out;   cpu_outr = vecs[i].outr;
      prn_ready = vecs[i].prdy; ien_set = vecs[i].iset; ien_clr = vecs[i].iclr;
      int_ack = vecs[i].iack;
      tick();
      got = {kbd_ready, inpr, fgi, fgo, prn_valid, prn_data, ien, irq, ovr};
      exp = {vecs[i].e_kr, vecs[i].e_inpr, vecs[i].e_fgi, vecs[i].e_fgo, vecs[i].e_pv,
             vecs[i].e_pd, vecs[i].e_ien, vecs[i].e_irq, vecs[i].e_ovr};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d: got {kr,inpr,fgi,fgo,pv,pd,ien,irq,ovr}=%h expected %h", i, got, exp);
      end
    end

    // FIFO fill: 5 bytes, one lands in INPR and four stay buffered; the sixth stalls.
    do_reset();
    kbd_valid = 1'b1;
    for (int b = 1; b <= 5; b++) begin
      kbd_data = 8'(b);
      tick();
    end
    check_b("fill_kr", kbd_ready, 1'b0);
    check_h("fill_inpr", inpr, 8'h01);
    check_b("fill_fgi", fgi, 1'b1);
    kbd_data = 8'h06;
    tick();
    tick();
    check_b("stall_kr", kbd_ready, 1'b0);
    kbd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_inp = 1'b1;
      tick();
      cpu_inp = 1'b0;
      check_b("drain_clr", fgi, 1'b0);
      wait_fgi("drain_fgi");
      check_h("drain_inpr", inpr, 8'(i + 2));
      check_b("drain_kr", kbd_ready, 1'b1);
    end
    cpu_inp = 1'b1;
    tick();
    cpu_inp = 1'b0;
    tick();
    tick();
    check_b("no_sixth_fgi", fgi, 1'b0);
    check_h("no_sixth_inpr", inpr, 8'h05);
    check_b("no_ovr_drain", ovr, 1'b0);

    // Reset during SEND with two bytes buffered.
    do_reset();
    cpu_inp = 1'b1;
    tick();
    cpu_inp = 1'b0;
    check_b("inp_ovr", ovr, 1'b1);
    check_h("inp_ovr_inpr", inpr, 8'h00);
    kbd_valid = 1'b1;
    kbd_data = 8'h11; tick();
    kbd_data = 8'h12; tick();
    kbd_data = 8'h13; tick();
    kbd_valid = 1'b0;
    check_h("pre_rst_inpr", inpr, 8'h11);
    cpu_out = 1'b1; cpu_outr = 8'h99;
    tick();
    cpu_out = 1'b0;
    check_b("pre_rst_pv", prn_valid, 1'b1);
    check_h("pre_rst_pd", prn_data, 8'h99);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_b("rst_pv", prn_valid, 1'b0);
    check_b("rst_fgo", fgo, 1'b1);
    check_b("rst_fgi", fgi, 1'b0);
    check_b("rst_kr", kbd_ready, 1'b1);
    check_b("rst_ovr", ovr, 1'b0);
    check_h("rst_pd", prn_data, 8'h00);
    check_h("rst_inpr", inpr, 8'h00);
    kbd_valid = 1'b1; kbd_data = 8'h33;
    tick();
    kbd_valid = 1'b0;
    check_b("post_push_fgi", fgi, 1'b0);
    tick();
    check_b("post_fgi", fgi, 1'b1);
    check_h("post_inpr", inpr, 8'h33);
    cpu_inp = 1'b1;
    tick();
    cpu_inp = 1'b0;
    tick();
    tick();
    check_b("post_discard_fgi", fgi, 1'b0);
    check_h("post_discard_inpr", inpr, 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
